// File: rtl/simmem_pkg.sv
// Shared constants and types for the simulated-memory write-response path.
package simmem_pkg;

   localparam int unsigned WRspBankCapa = 8;
   localparam int unsigned AxiIdW       = 4;
   localparam int unsigned AxiRespW     = 2;

   typedef struct packed {
      logic [AxiIdW-1:0]   id;
      logic [AxiRespW-1:0] resp;
   } wrsp_t;

   typedef enum logic [1:0] {
      SlotFree    = 2'd0,
      SlotWaitRsp = 2'd1,
      SlotHeld    = 2'd2,
      SlotOut     = 2'd3
   } wrsp_slot_state_e;

endpackage

// File: rtl/simmem_wrsp_release_bank_if.sv
// Handshake bundle of the write-response release bank; slave is the bank side.
interface simmem_wrsp_release_bank_if
   import simmem_pkg::*;
#(
   parameter int unsigned Capa  = WRspBankCapa,
   parameter int unsigned IdW   = AxiIdW,
   parameter int unsigned RespW = AxiRespW
) ();

   logic                    waddr_valid_i;
   logic [IdW-1:0]          waddr_id_i;
   logic                    waddr_ready_o;
   logic [$clog2(Capa)-1:0] waddr_iid_o;

   logic                    wrsp_in_valid_i;
   logic [IdW-1:0]          wrsp_in_id_i;
   logic [RespW-1:0]        wrsp_in_resp_i;
   logic                    wrsp_in_ready_o;

   logic [Capa-1:0]         release_en_mhot_i;

   logic                    wrsp_out_valid_o;
   logic [IdW-1:0]          wrsp_out_id_o;
   logic [RespW-1:0]        wrsp_out_resp_o;
   logic                    wrsp_out_ready_i;
   logic [Capa-1:0]         released_iid_onehot_o;

   modport slave (
      input  waddr_valid_i, waddr_id_i,
      output waddr_ready_o, waddr_iid_o,
      input  wrsp_in_valid_i, wrsp_in_id_i, wrsp_in_resp_i,
      output wrsp_in_ready_o,
      input  release_en_mhot_i,
      output wrsp_out_valid_o, wrsp_out_id_o, wrsp_out_resp_o,
      input  wrsp_out_ready_i,
      output released_iid_onehot_o
   );

   modport master (
      output waddr_valid_i, waddr_id_i,
      input  waddr_ready_o, waddr_iid_o,
      output wrsp_in_valid_i, wrsp_in_id_i, wrsp_in_resp_i,
      input  wrsp_in_ready_o,
      output release_en_mhot_i,
      input  wrsp_out_valid_o, wrsp_out_id_o, wrsp_out_resp_o,
      output wrsp_out_ready_i,
      input  released_iid_onehot_o
   );

endinterface

// File: rtl/simmem_age_matrix.sv
// Relative age of live slots: older_o[i][j] = 1 when slot j was allocated before slot i
// and both are still live.
module simmem_age_matrix #(
   parameter int unsigned Capa = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [Capa-1:0]           alloc_onehot_i,
   input  logic [Capa-1:0]           free_onehot_i,
   input  logic [Capa-1:0]           live_i,
   output logic [Capa-1:0][Capa-1:0] older_o
);

   logic [Capa-1:0][Capa-1:0] older_q, older_d;

   always_comb begin
      older_d = older_q;
      for (int i = 0; i < Capa; i++) begin
         for (int j = 0; j < Capa; j++) begin
            if (free_onehot_i[i] || free_onehot_i[j] || alloc_onehot_i[j]) begin
               older_d[i][j] = 1'b0;
            end
            // A new slot is younger than everything that survives this edge.
            if (alloc_onehot_i[i]) begin
               older_d[i][j] = live_i[j] && !free_onehot_i[j];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         older_q <= '0;
      end else begin
         older_q <= older_d;
      end
   end

   assign older_o = older_q;

endmodule

// File: rtl/simmem_wrsp_release_bank.sv
// Write-response bank: allocates iids, captures memory responses, releases them under
// calculator enable with per-ID ordering, and confirms each release one-hot.
module simmem_wrsp_release_bank
   import simmem_pkg::*;
#(
   parameter int unsigned Capa  = WRspBankCapa,
   parameter int unsigned IdW   = AxiIdW,
   parameter int unsigned RespW = AxiRespW
) (
   input logic                       clk_i,
   input logic                       rst_i,
   simmem_wrsp_release_bank_if.slave bus
);

   localparam int unsigned IdxW = $clog2(Capa);

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [RespW-1:0] resp;
   } slot_t;

   wrsp_slot_state_e state_q [Capa];
   wrsp_slot_state_e state_d [Capa];
   slot_t            slot_q  [Capa];
   slot_t            slot_d  [Capa];
   logic             out_valid_q, out_valid_d;
   logic [IdxW-1:0]  out_idx_q, out_idx_d;
   slot_t            out_q, out_d;

   logic [Capa-1:0] free_m, wait_m, held_m, live_m;
   logic [Capa-1:0] cap_m, cap_sel, blk_m, rel_m, rel_sel;
   logic [Capa-1:0] alloc_oh, free_oh;
   logic [Capa-1:0][Capa-1:0] older;
   logic [IdxW-1:0] alloc_idx, rel_idx;
   logic            waddr_ready, cap_ready;
   logic            alloc_hs, cap_hs, out_hs, load;

   simmem_age_matrix #(.Capa(Capa)) u_age (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .alloc_onehot_i (alloc_oh),
      .free_onehot_i  (free_oh),
      .live_i         (live_m),
      .older_o        (older)
   );

   for (genvar i = 0; i < Capa; i++) begin : g_slot
      logic [Capa-1:0] same_id;

      assign free_m[i] = (state_q[i] == SlotFree);
      assign wait_m[i] = (state_q[i] == SlotWaitRsp);
      assign held_m[i] = (state_q[i] == SlotHeld);
      assign live_m[i] = !free_m[i];

      // Oldest-match selection: no other matching slot is older than this one.
      assign cap_m[i]   = wait_m[i] && (slot_q[i].id == bus.wrsp_in_id_i);
      assign cap_sel[i] = cap_m[i] && !(|(older[i] & cap_m));

      for (genvar j = 0; j < Capa; j++) begin : g_cmp
         assign same_id[j] = (slot_q[j].id == slot_q[i].id);
      end

      assign blk_m[i]   = |(older[i] & live_m & same_id);
      assign rel_m[i]   = held_m[i] && bus.release_en_mhot_i[i] && !blk_m[i];
      assign rel_sel[i] = rel_m[i] && !(|(older[i] & rel_m));
   end

   always_comb begin
      alloc_idx = '0;
      rel_idx   = '0;
      for (int i = int'(Capa) - 1; i >= 0; i--) begin
         if (free_m[i]) alloc_idx = IdxW'(i);
      end
      for (int i = 0; i < int'(Capa); i++) begin
         if (rel_sel[i]) rel_idx = IdxW'(i);
      end
   end

   assign waddr_ready = |free_m;
   assign cap_ready   = |cap_m;
   assign alloc_hs    = bus.waddr_valid_i && waddr_ready;
   assign cap_hs      = bus.wrsp_in_valid_i && cap_ready;
   assign out_hs      = out_valid_q && bus.wrsp_out_ready_i;
   assign load        = (!out_valid_q || out_hs) && (|rel_m);
   assign alloc_oh    = alloc_hs ? (Capa'(1) << alloc_idx) : '0;
   assign free_oh     = out_hs ? (Capa'(1) << out_idx_q) : '0;

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_d       = out_q;

      if (alloc_hs) begin
         state_d[alloc_idx]   = SlotWaitRsp;
         slot_d[alloc_idx].id = bus.waddr_id_i;
      end

      // Allocation, capture, load and release always touch distinct slots.
      for (int i = 0; i < int'(Capa); i++) begin
         if (cap_hs && cap_sel[i]) begin
            state_d[i]     = SlotHeld;
            slot_d[i].resp = bus.wrsp_in_resp_i;
         end
         if (load && rel_sel[i]) state_d[i] = SlotOut;
         if (free_oh[i])         state_d[i] = SlotFree;
      end

      if (load) begin
         out_valid_d = 1'b1;
         out_idx_d   = rel_idx;
         out_d       = slot_q[rel_idx];
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Capa); i++) begin
            state_q[i] <= SlotFree;
            slot_q[i]  <= '0;
         end
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_q       <= '0;
      end else begin
         for (int i = 0; i < int'(Capa); i++) begin
            state_q[i] <= state_d[i];
            slot_q[i]  <= slot_d[i];
         end
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_q       <= out_d;
      end
   end

   assign bus.waddr_ready_o         = waddr_ready;
   assign bus.waddr_iid_o           = alloc_idx;
   assign bus.wrsp_in_ready_o       = cap_ready;
   assign bus.wrsp_out_valid_o      = out_valid_q;
   assign bus.wrsp_out_id_o         = out_q.id;
   assign bus.wrsp_out_resp_o       = out_q.resp;
   assign bus.released_iid_onehot_o = free_oh;

endmodule

// File: tb/tb_simmem_wrsp_release_bank.sv
// Directed bench for the write-response release bank with an expected-release scoreboard.
module tb_simmem_wrsp_release_bank;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
      int         iid;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q [$];

   always #5 clk = ~clk;

   simmem_wrsp_release_bank_if #(.Capa(8), .IdW(4), .RespW(2)) bus ();

   simmem_wrsp_release_bank #(.Capa(8), .IdW(4), .RespW(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_addr(input logic [3:0] id, input int exp_iid);
      bus.waddr_valid_i = 1'b1;
      bus.waddr_id_i    = id;
      #1;
      chk("addr_ready", 32'(bus.waddr_ready_o), 1);
      chk("addr_iid", 32'(bus.waddr_iid_o), 32'(exp_iid));
      tick();
      bus.waddr_valid_i = 1'b0;
   endtask

   task automatic do_rsp(input logic [3:0] id, input logic [1:0] resp);
      int n = 0;
      bus.wrsp_in_valid_i = 1'b1;
      bus.wrsp_in_id_i    = id;
      bus.wrsp_in_resp_i  = resp;
      #1;
      while (!bus.wrsp_in_ready_o && n < 10) begin
         tick();
         n++;
      end
      chk("rsp_ready", 32'(bus.wrsp_in_ready_o), 1);
      tick();
      bus.wrsp_in_valid_i = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      exp_t e;
      int   n = 0;
      e = exp_q.pop_front();
      while (!bus.wrsp_out_valid_o && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(bus.wrsp_out_valid_o), 1);
      chk({tag, "_id"}, 32'(bus.wrsp_out_id_o), 32'(e.id));
      chk({tag, "_resp"}, 32'(bus.wrsp_out_resp_o), 32'(e.resp));
      bus.wrsp_out_ready_i = 1'b1;
      #1;
      chk({tag, "_onehot"}, 32'(bus.released_iid_onehot_o), 32'(1) << e.iid);
      tick();
      bus.wrsp_out_ready_i = 1'b0;
   endtask

   initial begin
      bus.waddr_valid_i     = 1'b0;
      bus.waddr_id_i        = '0;
      bus.wrsp_in_valid_i   = 1'b0;
      bus.wrsp_in_id_i      = '0;
      bus.wrsp_in_resp_i    = '0;
      bus.release_en_mhot_i = '0;
      bus.wrsp_out_ready_i  = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_waddr_ready", 32'(bus.waddr_ready_o), 1);
      chk("rst_waddr_iid", 32'(bus.waddr_iid_o), 0);
      chk("rst_in_ready", 32'(bus.wrsp_in_ready_o), 0);
      chk("rst_out_valid", 32'(bus.wrsp_out_valid_o), 0);
      chk("rst_onehot", 32'(bus.released_iid_onehot_o), 0);

      // Single transaction with minimum latency
      do_addr(4'd3, 0);
      bus.release_en_mhot_i = 8'b0000_0001;
      exp_q.push_back('{id: 4'd3, resp: 2'd0, iid: 0});
      do_rsp(4'd3, 2'd0);
      chk("lat_held", 32'(bus.wrsp_out_valid_o), 0);
      tick();
      chk("lat_valid", 32'(bus.wrsp_out_valid_o), 1);
      wait_out("t1");
      chk("t1_free_valid", 32'(bus.wrsp_out_valid_o), 0);
      chk("t1_free_iid", 32'(bus.waddr_iid_o), 0);
      bus.release_en_mhot_i = '0;

      // Same ID must release in order even if the younger one is enabled first
      do_addr(4'd5, 0);
      do_addr(4'd5, 1);
      exp_q.push_back('{id: 4'd5, resp: 2'd1, iid: 0});
      exp_q.push_back('{id: 4'd5, resp: 2'd2, iid: 1});
      bus.release_en_mhot_i = 8'b0000_0010;
      do_rsp(4'd5, 2'd1);
      do_rsp(4'd5, 2'd2);
      for (int k = 0; k < 4; k++) tick();
      chk("t2_blocked", 32'(bus.wrsp_out_valid_o), 0);
      bus.release_en_mhot_i = 8'b0000_0011;
      wait_out("t2a");
      wait_out("t2b");
      bus.release_en_mhot_i = '0;

      // Different IDs may reorder
      do_addr(4'd1, 0);
      do_addr(4'd2, 1);
      do_rsp(4'd1, 2'd0);
      do_rsp(4'd2, 2'd3);
      exp_q.push_back('{id: 4'd2, resp: 2'd3, iid: 1});
      exp_q.push_back('{id: 4'd1, resp: 2'd0, iid: 0});
      bus.release_en_mhot_i = 8'b0000_0010;
      wait_out("t3a");
      bus.release_en_mhot_i = 8'b0000_0011;
      wait_out("t3b");
      bus.release_en_mhot_i = '0;

      // Full bank, then free the middle slot
      for (int k = 0; k < 8; k++) do_addr(4'(8 + k), k);
      #1;
      chk("full_ready", 32'(bus.waddr_ready_o), 0);
      bus.release_en_mhot_i = 8'b0001_0000;
      exp_q.push_back('{id: 4'd12, resp: 2'd1, iid: 4});
      do_rsp(4'd12, 2'd1);
      chk("full_still", 32'(bus.waddr_ready_o), 0);
      wait_out("t4");
      chk("refill_ready", 32'(bus.waddr_ready_o), 1);
      chk("refill_iid", 32'(bus.waddr_iid_o), 4);
      bus.release_en_mhot_i = '0;

      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Response with no waiting slot stalls until its address arrives
      bus.wrsp_in_valid_i = 1'b1;
      bus.wrsp_in_id_i    = 4'd7;
      bus.wrsp_in_resp_i  = 2'd2;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("orphan_ready", 32'(bus.wrsp_in_ready_o), 0);
         tick();
      end
      bus.waddr_valid_i = 1'b1;
      bus.waddr_id_i    = 4'd7;
      #1;
      chk("same_cyc_iid", 32'(bus.waddr_iid_o), 0);
      chk("same_cyc_stall", 32'(bus.wrsp_in_ready_o), 0);
      tick();
      bus.waddr_valid_i = 1'b0;
      #1;
      chk("next_cyc_ready", 32'(bus.wrsp_in_ready_o), 1);
      tick();
      bus.wrsp_in_valid_i   = 1'b0;
      bus.release_en_mhot_i = 8'b0000_0001;
      exp_q.push_back('{id: 4'd7, resp: 2'd2, iid: 0});

      // Back-pressure: output held stable without confirmation
      begin
         exp_t e;
         int   n = 0;
         e = exp_q.pop_front();
         while (!bus.wrsp_out_valid_o && n < 20) begin
            tick();
            n++;
         end
         for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(bus.wrsp_out_valid_o), 1);
            chk("stall_id", 32'(bus.wrsp_out_id_o), 32'(e.id));
            chk("stall_resp", 32'(bus.wrsp_out_resp_o), 32'(e.resp));
            chk("stall_onehot", 32'(bus.released_iid_onehot_o), 0);
            tick();
         end
      end

      // Reset mid-stall discards everything
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(bus.wrsp_out_valid_o), 0);
      chk("mid_rst_in_ready", 32'(bus.wrsp_in_ready_o), 0);
      bus.wrsp_out_ready_i = 1'b1;
      #1;
      chk("mid_rst_onehot", 32'(bus.released_iid_onehot_o), 0);
      bus.wrsp_out_ready_i = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 8; k++) do_addr(4'(k), k);
      #1;
      chk("mid_rst_full", 32'(bus.waddr_ready_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/simmem_wrsp_release_bank.md
Name: simmem_wrsp_release_bank

Overview:
Write-response bank directly downstream of the delay calculator.
- Allocates an internal identifier (iid = slot index) to each accepted write address.
- Stores the real write response from memory in that slot.
- Releases the response to the requester only when the calculator's release enable for that slot is set and AXI per-ID ordering allows it.
- Returns a one-hot release confirmation to the calculator.

Parameters:
Capa, 8, number of slots (equals simmem_pkg::WRspBankCapa; power of two, ≥2)
IdW, 4, AXI ID width
RespW, 2, BRESP width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
waddr_valid_i  in  1  write address accepted by requester path
waddr_id_i  in  IdW  AXI ID of the write address
waddr_ready_o  out  1  a free slot exists
waddr_iid_o  out  $clog2(Capa)  iid allocated on this handshake
wrsp_in_valid_i  in  1  response from real memory
wrsp_in_id_i  in  IdW  response AXI ID
wrsp_in_resp_i  in  RespW  response code
wrsp_in_ready_o  out  1  a matching slot can take the response
release_en_mhot_i  in  Capa  release enables from delay calculator
wrsp_out_valid_o  out  1  response to requester valid
wrsp_out_id_o  out  IdW  response AXI ID
wrsp_out_resp_o  out  RespW  response code
wrsp_out_ready_i  in  1  requester ready
released_iid_onehot_o  out  Capa  released-slot confirmation to delay calculator

Behaviour:
- Slot states: FREE, WAIT_RSP, HELD, OUT. Per slot, store id and resp.
- Reset (synchronous): all slots FREE, age matrix cleared, output register empty.
  - Outputs in the cycle after reset: waddr_ready_o=1, waddr_iid_o=0, wrsp_in_ready_o=0, wrsp_out_valid_o=0, released_iid_onehot_o=0.
  - Reset asserted mid-operation discards all content; no confirmations are emitted for discarded slots.
- Allocation:
  - waddr_ready_o = any slot FREE (from registered state).
  - waddr_iid_o = lowest-index FREE slot.
  - On handshake: slot goes FREE→WAIT_RSP and becomes youngest in the age matrix.
  - A slot freed in cycle t is allocatable from t+1, never in t.
- Response capture:
  - Target = oldest WAIT_RSP slot whose id == wrsp_in_id_i, using registered state.
  - wrsp_in_ready_o = target exists.
  - A response arriving in the same cycle as its own address is stalled one cycle (ready=0).
  - On handshake: target goes WAIT_RSP→HELD and stores resp.
- Release candidate: slot is HELD, release_en_mhot_i bit is 1, and no older non-FREE slot has the same id. This gives per-ID in-order release; different IDs may reorder.
- Output register:
  - Loads the oldest candidate when empty or on an output handshake (wrsp_out_valid_o && wrsp_out_ready_i).
  - Loaded slot goes HELD→OUT.
  - Minimum latency: response accepted at edge t with enable already high → HELD at t+1 → wrsp_out_valid_o at t+2.
  - Valid stays high and data stable until ready.
- Release:
  - On output handshake, released_iid_onehot_o = onehot(slot in register) in the same cycle (combinational), else 0.
  - That slot goes OUT→FREE at the next edge, and its age-matrix row/column is cleared.
- Enable deasserted after a slot has been loaded into the output register: no effect, the release completes.
- Full (all slots non-FREE): waddr_ready_o=0.
- Empty: wrsp_in_ready_o=0, no output.
- Simultaneous allocate, capture and release in one cycle all apply, touching distinct slots.

Decomposition:
- simmem_pkg holds:
  - WRspBankCapa and AXI ID/BRESP width constants.
  - wrsp_t typedef {id, resp}.
  - wrsp_slot_state_e enum.
- One sub-module, simmem_age_matrix:
  - Capa×Capa older-than bits, with set-youngest on allocate and clear on free.
  - Outputs a per-slot "older" vector that both the capture selection and the candidate selection reuse.

Test Plan:
- Reset, then addr id=3 → iid=0. Memory rsp id=3, OKAY; release_en[0]=1 → out valid 2 cycles later with id=3, resp=0; ready=1 → released_iid_onehot_o=8'b0000_0001, slot 0 FREE next cycle.
- Two addrs id=5 (iid 0, 1). Responses for both; release_en=8'b10 only → no output. Then en=8'b11 → iid0 then iid1 released in order.
- Addr id=1 (iid0), addr id=2 (iid1), both HELD; en=8'b10 → id=2 released first (cross-ID reorder permitted).
- Fill 8 slots → waddr_ready_o=0. Release iid4 → ready=1 next cycle and waddr_iid_o=4.
- Response id=7 with no WAIT_RSP slot for id 7 → wrsp_in_ready_o=0 until an addr id=7 is accepted, then accepted one cycle later.
- Hold wrsp_out_ready_i=0 for 5 cycles with valid high → id/resp stable, released_iid_onehot_o stays 0. Assert rst_i mid-stall → valid=0 and all slots FREE next cycle.
